// File: rtl/bf_pkg.sv
// bf_pkg: shared FSM encoding, default character range and candidate width for brute_force_gen
package bf_pkg;
    typedef enum logic [1:0] {
        BF_IDLE = 2'd0,
        BF_RUN  = 2'd1,
        BF_DONE = 2'd2
    } bf_state_t;
    localparam logic [7:0] BF_CHAR_LO   = 8'h61;
    localparam logic [7:0] BF_CHAR_HI   = 8'h7a;
    localparam int         BF_MAX_BYTES = 16;
endpackage

// File: rtl/bf_char_digit.sv
// bf_char_digit: one base-N digit add-with-carry over the range CHAR_LO..CHAR_HI
module bf_char_digit
    import bf_pkg::*;
#(
    parameter logic [7:0] CHAR_LO = BF_CHAR_LO,
    parameter logic [7:0] CHAR_HI = BF_CHAR_HI
) (
    input  logic [7:0] c,
    input  logic       cin,
    input  logic [2:0] addend,
    output logic [7:0] nc,
    output logic       cout
);
    localparam int N = int'(CHAR_HI) - int'(CHAR_LO) + 1;
    logic [8:0] v;
    // addend + cin never exceeds 8 <= N, so a single conditional subtract wraps the digit
    assign v    = {1'b0, c - CHAR_LO} + 9'(addend) + 9'(cin);
    assign cout = v >= 9'(N);
    assign nc   = 8'(cout ? v - 9'(N) : v) + CHAR_LO;
endmodule

// File: rtl/brute_force_gen.sv
// brute_force_gen: strided shortest-first password candidate enumerator with valid/ready output
// Optional build macro BF_MATCH_EN adds target/target_len/found and stops on the first match.
module brute_force_gen
    import bf_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] CHAR_LO = BF_CHAR_LO,
    parameter logic [7:0] CHAR_HI = BF_CHAR_HI
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic                        start,
    input  logic                        enable,
    input  logic [7:0]                  startingPosition,
    input  logic [2:0]                  increment,
    input  logic                        cand_ready,
`ifdef BF_MATCH_EN
    input  logic [8*BF_MAX_BYTES-1:0]   target,
    input  logic [7:0]                  target_len,
    output logic                        found,
`endif
    output logic                        cand_valid,
    output logic [7:0]                  wordLength,
    output logic [8*BF_MAX_BYTES-1:0]   password,
    output logic                        busy,
    output logic                        done
);
    localparam logic [1:0] IDLE = BF_IDLE;
    localparam logic [1:0] RUN  = BF_RUN;
    localparam logic [1:0] DONE = BF_DONE;

    logic [1:0]                state;
    logic [2:0]                stride;
    logic [MAX_LEN:0]          cy;
    logic [7:0]                sum [MAX_LEN];
    logic [8*BF_MAX_BYTES-1:0] nxt_pw;
    logic                      top_cy;
    logic                      grow;
    logic                      wrap;
    logic                      in_range;
    logic                      accept;
    logic                      hit;

    assign cy[0]      = 1'b0;
    assign in_range   = startingPosition >= CHAR_LO && startingPosition <= CHAR_HI;
    assign cand_valid = state == RUN && enable;
    assign busy       = state == RUN;
    assign done       = state == DONE;
    assign accept     = cand_valid && cand_ready;
    assign grow       = top_cy && int'(wordLength) < MAX_LEN;
    assign wrap       = top_cy && !grow;

    genvar d;
    for (d = 0; d < MAX_LEN; d++) begin : g_digit
        bf_char_digit #(
            .CHAR_LO (CHAR_LO),
            .CHAR_HI (CHAR_HI)
        ) u_digit (
            .c      (password[8*d +: 8]),
            .cin    (cy[d]),
            .addend (d == 0 ? stride : 3'd0),
            .nc     (sum[d]),
            .cout   (cy[d+1])
        );
    end

    // next candidate: live digits take the sum, the digit just above the top opens at CHAR_LO on carry-out
    always_comb begin
        nxt_pw = '0;
        top_cy = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(wordLength)) nxt_pw[8*i +: 8] = sum[i];
            if (i == int'(wordLength) && top_cy) nxt_pw[8*i +: 8] = CHAR_LO;
            if (i == int'(wordLength) - 1) top_cy = cy[i+1];
        end
    end

`ifdef BF_MATCH_EN
    assign hit = password == target && wordLength == target_len;

    // found latches on an accepted matching candidate and clears only on start
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
        if (!CPU_RESETN) found <= 1'b0;
        else if (start) found <= 1'b0;
        else if (accept && hit) found <= 1'b1;
`else
    assign hit = 1'b0;
`endif

    // FSM and candidate register; start overrides the handshake, a match or final wrap freezes the candidate
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            state      <= IDLE;
            stride     <= 3'd0;
            wordLength <= 8'd0;
            password   <= '0;
        end else if (start) begin
            state      <= in_range ? RUN : DONE;
            stride     <= increment == 3'd0 ? 3'd1 : increment;
            wordLength <= in_range ? 8'd1 : 8'd0;
            password   <= in_range ? {{(8*BF_MAX_BYTES-8){1'b0}}, startingPosition} : '0;
        end else if (accept) begin
            if (hit || wrap) state <= DONE;
            else begin
                password   <= nxt_pw;
                wordLength <= grow ? wordLength + 8'd1 : wordLength;
            end
        end
endmodule

// File: tb/tb_brute_force_gen.sv
// tb_brute_force_gen: directed self-checking bench for brute_force_gen with MAX_LEN=2 over a..z
module tb_brute_force_gen;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         enable = 1'b1;
    logic [7:0]   sp = 8'h61;
    logic [2:0]   inc = 3'd1;
    logic         ready = 1'b1;
    logic         cand_valid;
    logic [7:0]   word_len;
    logic [127:0] password;
    logic         busy;
    logic         done;
`ifdef BF_MATCH_EN
    logic [127:0] target = '0;
    logic [7:0]   target_len = 8'd0;
    logic         found;
`endif
    int compared = 0;
    int mismatched = 0;

    brute_force_gen #(.MAX_LEN(2)) dut (
        .CLK100MHZ        (clk),
        .CPU_RESETN       (rst_n),
        .start            (start),
        .enable           (enable),
        .startingPosition (sp),
        .increment        (inc),
        .cand_ready       (ready),
`ifdef BF_MATCH_EN
        .target           (target),
        .target_len       (target_len),
        .found            (found),
`endif
        .cand_valid       (cand_valid),
        .wordLength       (word_len),
        .password         (password),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input logic [7:0] p, input logic [2:0] s);
        sp = p;
        inc = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [127:0] last;
        #2;
        chk("rst_valid", 128'(cand_valid), 128'(0));
        chk("rst_len", 128'(word_len), 128'(0));
        chk("rst_pw", password, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        #10 rst_n = 1'b1;
        tick();
        chk("idle_valid", 128'(cand_valid), 128'(0));

        go(8'h61, 3'd1);
        chk("s1_first", password, 128'("a"));
        chk("s1_first_len", 128'(word_len), 128'(1));
        chk("s1_first_valid", 128'(cand_valid), 128'(1));
        chk("s1_busy", 128'(busy), 128'(1));
        ticks(25);
        chk("s1_z", password, 128'("z"));
        chk("s1_z_len", 128'(word_len), 128'(1));
        tick();
        chk("s1_aa", password, 128'("aa"));
        chk("s1_aa_len", 128'(word_len), 128'(2));
        tick();
        chk("s1_ab", password, 128'("ab"));

        go(8'h63, 3'd3);
        chk("s3_c", password, 128'("c"));
        tick();
        chk("s3_f", password, 128'("f"));
        ticks(6);
        chk("s3_x", password, 128'("x"));
        tick();
        chk("s3_aa", password, 128'("aa"));
        chk("s3_aa_len", 128'(word_len), 128'(2));
        tick();
        chk("s3_ad", password, 128'("ad"));

        go(8'h61, 3'd1);
        ticks(16);
        chk("bp_q", password, 128'("q"));
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_pw", password, 128'("q"));
            chk("bp_hold_valid", 128'(cand_valid), 128'(1));
        end
        ready = 1'b1;
        tick();
        chk("bp_r", password, 128'("r"));
        enable = 1'b0;
        #1;
        chk("en_off_valid", 128'(cand_valid), 128'(0));
        tick();
        chk("en_off_hold", password, 128'("r"));
        enable = 1'b1;
        tick();
        chk("en_on_s", password, 128'("s"));

        go(8'h61, 3'd1);
        n = 0;
        last = '0;
        while (cand_valid && n < 800) begin
            n++;
            last = password;
            tick();
        end
        chk("ex_count", 128'(n), 128'(702));
        chk("ex_last", last, 128'("zz"));
        chk("ex_done", 128'(done), 128'(1));
        chk("ex_busy", 128'(busy), 128'(0));
        chk("ex_valid", 128'(cand_valid), 128'(0));
        chk("ex_hold", password, 128'("zz"));
        ticks(2);
        chk("ex_stay_done", 128'(done), 128'(1));

        go(8'h61, 3'd0);
        chk("inc0_restart_done", 128'(done), 128'(0));
        tick();
        chk("inc0_b", password, 128'("b"));
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 128'(cand_valid), 128'(0));
        chk("ar_len", 128'(word_len), 128'(0));
        chk("ar_pw", password, 128'(0));
        chk("ar_busy", 128'(busy), 128'(0));
        #1 rst_n = 1'b1;
        tick();
        chk("ar_idle_busy", 128'(busy), 128'(0));
        chk("ar_idle_done", 128'(done), 128'(0));
        go(8'h7b, 3'd1);
        chk("oor_done", 128'(done), 128'(1));
        chk("oor_valid", 128'(cand_valid), 128'(0));
        chk("oor_busy", 128'(busy), 128'(0));
        tick();
        chk("oor_still_invalid", 128'(cand_valid), 128'(0));
        go(8'h60, 3'd1);
        chk("oor_low_done", 128'(done), 128'(1));

`ifdef BF_MATCH_EN
        target = 128'("ac");
        target_len = 8'd2;
        go(8'h61, 3'd1);
        chk("m_found_clr", 128'(found), 128'(0));
        ticks(28);
        chk("m_ac_vis", password, 128'("ac"));
        chk("m_not_yet", 128'(found), 128'(0));
        tick();
        chk("m_found", 128'(found), 128'(1));
        chk("m_done", 128'(done), 128'(1));
        chk("m_hold", password, 128'("ac"));
        chk("m_valid", 128'(cand_valid), 128'(0));
        go(8'h61, 3'd1);
        chk("m_start_clr", 128'(found), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
